// File: rtl/aq_gemac_tx_arb.sv
// Frame-level arbiter sharing the GEMAC TX buffer write port among three packet sources.
// Define AQ_TXARB_PRIO_EN for fixed priority (0 > 1 > 2) instead of round-robin.
module aq_gemac_tx_arb #(
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  src_req,
  output logic [2:0]  src_gnt,
  output logic        src_ready,
  input  logic [2:0]  src_we,
  input  logic [2:0]  src_end,
  input  logic [95:0] src_data,
  input  logic        tx_buff_ready,
  input  logic        tx_buff_full,
  output logic        tx_buff_we,
  output logic        tx_buff_start,
  output logic        tx_buff_end,
  output logic [31:0] tx_buff_data,
  output logic        arb_abort
);

  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);
  localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StXfer, StGap} state_e;

  state_e            state_q, state_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [StallW-1:0] stall_q, stall_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              started_q, started_d;
  logic              we_q, we_d;
  logic              start_q, start_d;
  logic              end_q, end_d;
  logic [31:0]       data_q, data_d;
  logic              abort_q, abort_d;

  logic [1:0]        win;
  logic              sel_we;
  logic              sel_end;
  logic [31:0]       sel_data;
  logic              abort_pend;
  logic              accepted;

  assign sel_we   = |(src_we & gnt_q);
  assign sel_end  = |(src_end & gnt_q);
  assign sel_data = ({32{gnt_q[0]}} & src_data[31:0])
                  | ({32{gnt_q[1]}} & src_data[63:32])
                  | ({32{gnt_q[2]}} & src_data[95:64]);

  // Once the stall limit is reached the source is locked out until the abort word drains.
  assign abort_pend = (stall_q == StallW'(STALL_LIMIT));
  assign src_ready  = (|gnt_q) & ~tx_buff_full & ~abort_pend;
  assign accepted   = sel_we & src_ready;

`ifdef AQ_TXARB_PRIO_EN
  always_comb begin
    if (src_req[0])      win = 2'd0;
    else if (src_req[1]) win = 2'd1;
    else                 win = 2'd2;
  end
`else
  logic [1:0]  rr_q, rr_d;
  int unsigned cand;
  logic        found;

  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < 3; k++) begin
      cand = (32'(rr_q) + 32'(k)) % 3;
      if (!found && src_req[cand]) begin
        win   = 2'(cand);
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    stall_d   = stall_q;
    gap_d     = gap_q;
    started_d = started_q;
    we_d      = 1'b0;
    start_d   = 1'b0;
    end_d     = 1'b0;
    data_d    = data_q;
    abort_d   = 1'b0;
`ifndef AQ_TXARB_PRIO_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      StIdle: begin
        if ((|src_req) && tx_buff_ready) begin
          gnt_d     = 3'b001 << win;
          stall_d   = '0;
          started_d = 1'b0;
          state_d   = StXfer;
`ifndef AQ_TXARB_PRIO_EN
          rr_d      = (win == 2'd2) ? 2'd0 : win + 2'd1;
`endif
        end
      end
      StXfer: begin
        if (abort_pend) begin
          if (!tx_buff_full) begin
            we_d    = 1'b1;
            start_d = ~started_q;
            end_d   = 1'b1;
            data_d  = '0;
            abort_d = 1'b1;
            gnt_d   = '0;
            stall_d = '0;
            gap_d   = '0;
            state_d = StGap;
          end
        end else if (accepted) begin
          we_d      = 1'b1;
          start_d   = ~started_q;
          end_d     = sel_end;
          data_d    = sel_data;
          started_d = 1'b1;
          stall_d   = '0;
          if (sel_end) begin
            gnt_d   = '0;
            gap_d   = '0;
            state_d = StGap;
          end
        end else if (tx_buff_full) begin
          stall_d = '0;
        end else begin
          stall_d = stall_q + StallW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYCLES - 1)) state_d = StIdle;
        else                                gap_d   = gap_q + GapW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      stall_q   <= '0;
      gap_q     <= '0;
      started_q <= 1'b0;
      we_q      <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      data_q    <= '0;
      abort_q   <= 1'b0;
`ifndef AQ_TXARB_PRIO_EN
      rr_q      <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      stall_q   <= stall_d;
      gap_q     <= gap_d;
      started_q <= started_d;
      we_q      <= we_d;
      start_q   <= start_d;
      end_q     <= end_d;
      data_q    <= data_d;
      abort_q   <= abort_d;
`ifndef AQ_TXARB_PRIO_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign src_gnt       = gnt_q;
  assign tx_buff_we    = we_q;
  assign tx_buff_start = start_q;
  assign tx_buff_end   = end_q;
  assign tx_buff_data  = data_q;
  assign arb_abort     = abort_q;

endmodule

// File: tb/tb_aq_gemac_tx_arb.sv
// Randomized bench for aq_gemac_tx_arb: source agents plus a frame-level reference model.
module tb_aq_gemac_tx_arb;

  localparam int GAP = 4;
  localparam int LIM = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  src_req, src_gnt, src_we, src_end;
  logic        src_ready;
  logic [95:0] src_data;
  logic        tx_buff_ready, tx_buff_full;
  logic        tx_buff_we, tx_buff_start, tx_buff_end, arb_abort;
  logic [31:0] tx_buff_data;

  always #5 clk = ~clk;

  aq_gemac_tx_arb #(.GAP_CYCLES(GAP), .STALL_LIMIT(LIM)) dut (
    .clk           (clk),
    .rst           (rst),
    .src_req       (src_req),
    .src_gnt       (src_gnt),
    .src_ready     (src_ready),
    .src_we        (src_we),
    .src_end       (src_end),
    .src_data      (src_data),
    .tx_buff_ready (tx_buff_ready),
    .tx_buff_full  (tx_buff_full),
    .tx_buff_we    (tx_buff_we),
    .tx_buff_start (tx_buff_start),
    .tx_buff_end   (tx_buff_end),
    .tx_buff_data  (tx_buff_data),
    .arb_abort     (arb_abort)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the port, how many gap cycles remain, idle grant cycles.
  int          m_phase;   // 0 waiting for a grant, 1 frame open, 2 gap
  int          m_owner;
  int          m_rr;
  int          m_stall;
  int          m_gap;
  bit          m_started;
  logic        e_we, e_start, e_end, e_abort;
  logic [31:0] e_data;

  // Source agents
  bit          has_frame[3];
  bit          seen[3];
  int          flen[3];
  int          fidx[3];
  int          fstall[3];
  logic [31:0] words[3][8];

  task automatic model_reset();
    m_phase = 0; m_owner = -1; m_rr = 0; m_stall = 0; m_gap = 0; m_started = 0;
    e_we = 0; e_start = 0; e_end = 0; e_abort = 0; e_data = '0;
    for (int s = 0; s < 3; s++) begin
      has_frame[s] = 0; seen[s] = 0; fidx[s] = 0; flen[s] = 0; fstall[s] = -1;
    end
  endtask

  task automatic frame_done(input int g);
    m_owner = -1; m_phase = 2; m_gap = GAP;
    has_frame[g] = 0; seen[g] = 0;
  endtask

  task automatic drive(input int cyc);
    int phase;
    int len;
    phase = (cyc / 1500) % 4;
    rst = (cyc == 0) || (cyc == 1000) || ($urandom % 400 == 0);
    case (phase)
      0:       begin tx_buff_full = ($urandom % 4 == 0); tx_buff_ready = ($urandom % 5 != 0); end
      1:       begin tx_buff_full = 1'b0;                tx_buff_ready = 1'b1;              end
      2:       begin tx_buff_full = ($urandom % 2 == 0); tx_buff_ready = ($urandom % 2 == 0); end
      default: begin tx_buff_full = ($urandom % 8 == 0); tx_buff_ready = ($urandom % 3 == 0); end
    endcase
    for (int s = 0; s < 3; s++) begin
      if (!has_frame[s] && (phase == 1 || $urandom % 4 == 0)) begin
        len = 1 + int'($urandom % 8);
        flen[s] = len;
        fidx[s] = 0;
        fstall[s] = ($urandom % 5 == 0) ? int'($urandom % len) : -1;
        words[s][0] = {16'(len), 16'h0};
        for (int k = 1; k < 8; k++) words[s][k] = $urandom;
        has_frame[s] = 1;
        seen[s] = 0;
      end
      if (m_owner == s) seen[s] = 1;
      src_req[s] = has_frame[s] && !seen[s];
      if (m_owner == s) begin
        if (fidx[s] != fstall[s]) begin
          src_we[s] = ($urandom % 4 != 0);
          src_end[s] = (fidx[s] == flen[s] - 1);
          src_data[32*s +: 32] = words[s][fidx[s]];
        end else begin
          src_we[s] = 1'b0;
          src_end[s] = 1'($urandom);
          src_data[32*s +: 32] = $urandom;
        end
      end else begin
        // Idle sources chatter on their strobes; none of it may reach the buffer.
        src_we[s] = 1'($urandom);
        src_end[s] = 1'($urandom);
        src_data[32*s +: 32] = $urandom;
      end
    end
  endtask

  task automatic step();
    int g;
    int w;
    if (rst) begin
      model_reset();
      return;
    end
    e_we = 0; e_start = 0; e_end = 0; e_abort = 0;
    case (m_phase)
      0: begin
        if (tx_buff_ready && src_req != 3'b000) begin
          w = -1;
`ifdef AQ_TXARB_PRIO_EN
          for (int k = 2; k >= 0; k--) if (src_req[k]) w = k;
`else
          for (int k = 2; k >= 0; k--) if (src_req[(m_rr + k) % 3]) w = (m_rr + k) % 3;
          m_rr = (w + 1) % 3;
`endif
          m_owner = w; m_stall = 0; m_started = 0; m_phase = 1;
        end
      end
      1: begin
        g = m_owner;
        if (m_stall == LIM) begin
          if (!tx_buff_full) begin
            e_we = 1; e_end = 1; e_start = !m_started; e_data = '0; e_abort = 1;
            frame_done(g);
          end
        end else if (src_we[g] && !tx_buff_full) begin
          e_we = 1; e_start = !m_started; e_end = src_end[g]; e_data = src_data[32*g +: 32];
          m_started = 1; m_stall = 0;
          fidx[g]++;
          if (src_end[g]) frame_done(g);
        end else if (tx_buff_full) begin
          m_stall = 0;
        end else begin
          m_stall++;
        end
      end
      default: begin
        m_gap--;
        if (m_gap == 0) m_phase = 0;
      end
    endcase
  endtask

  initial begin
    logic [2:0] e_gnt;
    rst = 1'b1;
    src_req = '0; src_we = '0; src_end = '0; src_data = '0;
    tx_buff_ready = 1'b0; tx_buff_full = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      e_gnt = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
      check_eq("gnt", 64'(src_gnt), 64'(e_gnt));
      check_eq("we", 64'(tx_buff_we), 64'(e_we));
      check_eq("abort", 64'(arb_abort), 64'(e_abort));
      if (e_we) begin
        check_eq("start", 64'(tx_buff_start), 64'(e_start));
        check_eq("end", 64'(tx_buff_end), 64'(e_end));
        check_eq("data", 64'(tx_buff_data), 64'(e_data));
      end
      drive(cyc);
      #1;
      check_eq("ready", 64'(src_ready), 64'((m_owner >= 0) && !tx_buff_full && (m_stall != LIM)));
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
